// File: rtl/ibex_ex_wb_buffer.sv
// ibex_ex_wb_buffer: in-order writeback FIFO between EX and the register-file
// write port. It also holds the sticky vxsat saturation flag.
// Optional feature macro: IBEX_WB_FWD_EN adds a lookup port that forwards the
// youngest pending result to ID.
module ibex_ex_wb_buffer #(
  parameter int unsigned Depth   = 2,
  parameter bit          VxsatEn = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [31:0] ex_result_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_rd_we_i,
  input  logic        ex_vxsat_set_i,
  input  logic        flush_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  input  logic        rf_ready_i,
  output logic        busy_o,
  input  logic        vxsat_we_i,
  input  logic        vxsat_wdata_i,
  output logic        vxsat_o
`ifdef IBEX_WB_FWD_EN
  ,
  input  logic [4:0]  fwd_raddr_i,
  output logic        fwd_hit_o,
  output logic [31:0] fwd_data_o
`endif
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [31:0]     data_q  [Depth];
  logic [4:0]      addr_q  [Depth];
  logic [Depth-1:0] valid_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic accept;
  logic push;
  logic pop;

  // Pointer advance with wrap at Depth; a single-entry buffer never moves.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (Depth == 1) return '0;
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Readiness comes from registered occupancy only, so a full buffer refuses
  // a push even when the head drains in the same cycle.
  assign ex_ready_o = (count_q != CntW'(Depth));
  assign accept     = ex_valid_i & ex_ready_o;
  assign push       = accept & ex_rd_we_i & (ex_rd_addr_i != 5'd0) & ~flush_i;

  assign busy_o     = (count_q != '0);
  assign rf_we_o    = busy_o;
  assign rf_waddr_o = busy_o ? addr_q[rd_ptr_q] : 5'd0;
  assign rf_wdata_o = busy_o ? data_q[rd_ptr_q] : 32'd0;
  assign pop        = rf_we_o & rf_ready_i;

  // FIFO storage, pointers and occupancy; flush discards everything pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q]  <= ex_result_i;
        addr_q[wr_ptr_q]  <= ex_rd_addr_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  if (VxsatEn) begin : g_vxsat
    logic vxsat_q;

    // Sticky saturation flag; a saturation event beats a same-cycle CSR clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vxsat_q <= 1'b0;
      end else begin
        vxsat_q <= (vxsat_we_i ? vxsat_wdata_i : vxsat_q) | (accept & ex_vxsat_set_i);
      end
    end

    assign vxsat_o = vxsat_q;
  end else begin : g_no_vxsat
    assign vxsat_o = 1'b0;
  end

`ifdef IBEX_WB_FWD_EN
  logic [PtrW-1:0] fwd_idx;

  // Walk entries oldest to youngest so the last match is the youngest one.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    fwd_idx    = rd_ptr_q;
    for (int i = 0; i < Depth; i++) begin
      fwd_idx = PtrW'((int'(rd_ptr_q) + i) % Depth);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx] == fwd_raddr_i) && (fwd_raddr_i != 5'd0)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[fwd_idx];
      end
    end
  end
`endif

endmodule
